alu_flag_consumer: RTL and testbench

// - Receiving end of the ALU flag path: registers the per-operation flags (N, Z, C, V) produced
//   by the 4-bit ALU flag generators, keeps sticky overflow and a negative-result counter.
// - Answers condition queries from the control unit over a req/ack handshake (branch decisions).
// - Sits between the ALU flag outputs and the sequencer/controller.

---
 rtl/alu_flag_consumer_pkg.sv | 42 ++++
 rtl/alu_cond_eval.sv | 26 ++
 rtl/alu_flag_consumer.sv | 126 ++++++++++++
 tb/tb_alu_flag_consumer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_flag_consumer_pkg.sv
// Shared definitions for the ALU flag consumer: opcodes, condition codes, FSM states, flag payload.
package alu_flag_consumer_pkg;

  localparam int unsigned OP_W          = 3;
  localparam int unsigned CC_W          = 3;
  localparam int unsigned FLAG_W        = 4;
  localparam int unsigned CNT_W_DEFAULT = 4;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_MUL = 3'b101;
  localparam logic [OP_W-1:0] OP_DIV = 3'b110;

  // Bit k set means opcode k is arithmetic and updates N, C and V.
  localparam logic [7:0] ARITH_MASK_DEFAULT = 8'b0110_0011;

  typedef enum logic [CC_W-1:0] {
    CC_ALWAYS = 3'b000,
    CC_EQ     = 3'b001,
    CC_NE     = 3'b010,
    CC_MI     = 3'b011,
    CC_PL     = 3'b100,
    CC_CS     = 3'b101,
    CC_VS     = 3'b110,
    CC_LT     = 3'b111
  } cc_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EVAL = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Packed so that the bus view is {N,Z,C,V} with N in the MSB.
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/alu_cond_eval.sv
// Combinational condition evaluator: registered flags + condition code -> condition result.
module alu_cond_eval
  import alu_flag_consumer_pkg::*;
(
  input  flags_t          flags,
  input  logic [CC_W-1:0] cond_code,
  output logic            cond_true_c
);

  // Decode the condition code against the flag set.
  always_comb begin
    cond_true_c = 1'b0;
    case (cc_e'(cond_code))
      CC_ALWAYS: cond_true_c = 1'b1;
      CC_EQ:     cond_true_c = flags.z;
      CC_NE:     cond_true_c = ~flags.z;
      CC_MI:     cond_true_c = flags.n;
      CC_PL:     cond_true_c = ~flags.n;
      CC_CS:     cond_true_c = flags.c;
      CC_VS:     cond_true_c = flags.v;
      CC_LT:     cond_true_c = flags.n ^ flags.v;
      default:   cond_true_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_flag_consumer.sv
// Receiving end of the ALU flag path: flag register, sticky overflow, negative counter, query FSM.
module alu_flag_consumer
  import alu_flag_consumer_pkg::*;
#(
  parameter int unsigned CNT_W      = CNT_W_DEFAULT,
  parameter logic [7:0]  ARITH_MASK = ARITH_MASK_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              res_valid,
  input  logic [OP_W-1:0]   op,
  input  logic              neg_in,
  input  logic              zero_in,
  input  logic              carry_in,
  input  logic              ovf_in,
  input  logic              clr_sticky,
  input  logic              cond_req,
  input  logic [CC_W-1:0]   cond_code,
  output logic [FLAG_W-1:0] flags,
  output logic              sticky_ovf,
  output logic [CNT_W-1:0]  neg_count,
  output logic              busy,
  output logic              cond_ack,
  output logic              cond_true
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  flags_t          flags_q;
  logic            arith_cap;
  logic            eval_c;
  state_e          state_q, state_d;
  logic [CC_W-1:0] code_q, code_d;
  logic            busy_d, ack_d, true_d;

  assign flags     = flags_q;
  assign arith_cap = res_valid & ARITH_MASK[op];

  // Flag capture: Z follows every op, N/C/V only arithmetic ops.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
    end else if (res_valid) begin
      flags_q.z <= zero_in;
      if (ARITH_MASK[op]) begin
        flags_q.n <= neg_in;
        flags_q.c <= carry_in;
        flags_q.v <= ovf_in;
      end
    end
  end

  // Sticky overflow; a set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_ovf <= 1'b0;
    end else if (arith_cap && ovf_in) begin
      sticky_ovf <= 1'b1;
    end else if (clr_sticky) begin
      sticky_ovf <= 1'b0;
    end
  end

  // Saturating negative-result counter; clear plus increment restarts at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_count <= '0;
    end else if (arith_cap && neg_in) begin
      if (clr_sticky) begin
        neg_count <= CNT_W'(1);
      end else if (neg_count != CNT_MAX) begin
        neg_count <= neg_count + CNT_W'(1);
      end
    end else if (clr_sticky) begin
      neg_count <= '0;
    end
  end

  alu_cond_eval u_cond_eval (
    .flags       (flags_q),
    .cond_code   (code_q),
    .cond_true_c (eval_c)
  );

  // Query FSM next state and next registered outputs.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    ack_d   = 1'b0;
    true_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cond_req) begin
          state_d = ST_EVAL;
          code_d  = cond_code;
        end
      end
      ST_EVAL: begin
        state_d = ST_RESP;
        ack_d   = 1'b1;
        true_d  = eval_c;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Query FSM state and output registers; reset aborts any query in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      code_q    <= '0;
      busy      <= 1'b0;
      cond_ack  <= 1'b0;
      cond_true <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      busy      <= busy_d;
      cond_ack  <= ack_d;
      cond_true <= true_d;
    end
  end

endmodule

// File: tb/tb_alu_flag_consumer.sv
// Self-checking bench for alu_flag_consumer: directed scenarios plus randomized traffic vs a reference model.
module tb_alu_flag_consumer;

  logic       clk = 1'b0;
  logic       rst, res_valid, neg_in, zero_in, carry_in, ovf_in, clr_sticky, cond_req;
  logic [2:0] op, cond_code;
  logic [3:0] flags;
  logic       sticky_ovf, busy, cond_ack, cond_true;
  logic [3:0] neg_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit [3:0] m_flags;
  bit       m_sticky;
  int       m_cnt;
  int       edge_n;
  int       req_edge;
  bit       req_res;

  always #5 clk = ~clk;

  alu_flag_consumer dut (
    .clk        (clk),
    .rst        (rst),
    .res_valid  (res_valid),
    .op         (op),
    .neg_in     (neg_in),
    .zero_in    (zero_in),
    .carry_in   (carry_in),
    .ovf_in     (ovf_in),
    .clr_sticky (clr_sticky),
    .cond_req   (cond_req),
    .cond_code  (cond_code),
    .flags      (flags),
    .sticky_ovf (sticky_ovf),
    .neg_count  (neg_count),
    .busy       (busy),
    .cond_ack   (cond_ack),
    .cond_true  (cond_true)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_cond(input bit [3:0] f, input int code);
    bit tbl [8];
    tbl = '{1'b1, f[2], !f[2], f[3], !f[3], f[1], f[0], f[3] ^ f[0]};
    return tbl[code];
  endfunction

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_edge();
    bit arith, busy_pre;
    edge_n++;
    if (rst) begin
      m_flags  = '0;
      m_sticky = 1'b0;
      m_cnt    = 0;
      req_edge = -10;
    end else begin
      arith = (op inside {3'd0, 3'd1, 3'd5, 3'd6});
      if (res_valid) begin
        m_flags[2] = zero_in;
        if (arith) begin
          m_flags[3] = neg_in;
          m_flags[1] = carry_in;
          m_flags[0] = ovf_in;
        end
      end
      if (res_valid && arith && ovf_in) m_sticky = 1'b1;
      else if (clr_sticky)              m_sticky = 1'b0;
      if (res_valid && arith && neg_in) m_cnt = clr_sticky ? 1 : ((m_cnt < 15) ? m_cnt + 1 : 15);
      else if (clr_sticky)              m_cnt = 0;
      busy_pre = (edge_n == req_edge + 1) || (edge_n == req_edge + 2);
      if (cond_req && !busy_pre) begin
        req_edge = edge_n;
        req_res  = model_cond(m_flags, int'(cond_code));
      end
    end
  endtask

  task automatic tick();
    bit e_busy, e_ack;
    @(posedge clk);
    model_edge();
    #1;
    e_busy = (edge_n == req_edge) || (edge_n == req_edge + 1);
    e_ack  = (edge_n == req_edge + 1);
    check_eq("flags",      32'(flags),      32'(m_flags));
    check_eq("sticky_ovf", 32'(sticky_ovf), 32'(m_sticky));
    check_eq("neg_count",  32'(neg_count),  32'(m_cnt));
    check_eq("busy",       32'(busy),       32'(e_busy));
    check_eq("cond_ack",   32'(cond_ack),   32'(e_ack));
    check_eq("cond_true",  32'(cond_true),  32'(e_ack & req_res));
  endtask

  task automatic idle_inputs();
    rst = 1'b0; res_valid = 1'b0; clr_sticky = 1'b0; cond_req = 1'b0;
  endtask

  task automatic capture(input bit [2:0] o, input bit n, input bit z, input bit c, input bit v);
    res_valid = 1'b1; op = o; neg_in = n; zero_in = z; carry_in = c; ovf_in = v;
  endtask

  initial begin
    m_flags = '0; m_sticky = 1'b0; m_cnt = 0; edge_n = 0; req_edge = -10; req_res = 1'b0;
    idle_inputs();
    op = 3'd0; neg_in = 1'b0; zero_in = 1'b0; carry_in = 1'b0; ovf_in = 1'b0; cond_code = 3'd0;

    // Reset dominates a concurrent negative, overflowing capture
    rst = 1'b1;
    capture(3'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    tick();
    check_eq("rst_flags", 32'(flags), 32'h0);
    check_eq("rst_cnt",   32'(neg_count), 32'h0);
    check_eq("rst_sticky", 32'(sticky_ovf), 32'h0);
    idle_inputs();
    tick();

    // ADD N=1 Z=0 C=1 V=1
    capture(3'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    check_eq("add_flags",  32'(flags), 32'hb);
    check_eq("add_sticky", 32'(sticky_ovf), 32'h1);
    check_eq("add_cnt",    32'(neg_count), 32'h1);

    // Non-arithmetic op only touches Z
    capture(3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check_eq("and_flags", 32'(flags), 32'hf);
    idle_inputs();

    // LT with N=1 V=1 -> false; extra requests while busy are dropped
    cond_req = 1'b1; cond_code = 3'd7;
    tick();
    cond_code = 3'd0;
    tick();
    check_eq("lt_ack",  32'(cond_ack), 32'h1);
    check_eq("lt_true", 32'(cond_true), 32'h0);
    tick();
    cond_req = 1'b0;
    tick();
    check_eq("drop_ack", 32'(cond_ack), 32'h0);
    tick();
    check_eq("drop_ack2", 32'(cond_ack), 32'h0);

    // Capture and EQ query in the same cycle: query sees the new Z
    capture(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    capture(3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cond_req = 1'b1; cond_code = 3'd1;
    tick();
    idle_inputs();
    tick();
    check_eq("eq_ack",  32'(cond_ack), 32'h1);
    check_eq("eq_true", 32'(cond_true), 32'h1);
    tick();

    // Counter saturation, then clear collides with increment and overflow set
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    for (int i = 0; i < 16; i++) begin
      capture(3'd1, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      tick();
    end
    check_eq("sat_cnt", 32'(neg_count), 32'hf);
    capture(3'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    clr_sticky = 1'b1;
    tick();
    check_eq("clr_inc_cnt",    32'(neg_count), 32'h1);
    check_eq("clr_set_sticky", 32'(sticky_ovf), 32'h1);
    idle_inputs();
    tick();

    // Reset during EVAL aborts the query
    cond_req = 1'b1; cond_code = 3'd0;
    tick();
    cond_req = 1'b0; rst = 1'b1;
    tick();
    check_eq("abort_ack", 32'(cond_ack), 32'h0);
    rst = 1'b0;
    tick();
    check_eq("abort_ack2", 32'(cond_ack), 32'h0);
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      rst        = ($urandom_range(0, 63) == 0);
      res_valid  = 1'($urandom_range(0, 1));
      op         = 3'($urandom_range(0, 7));
      neg_in     = 1'($urandom_range(0, 1));
      zero_in    = 1'($urandom_range(0, 1));
      carry_in   = 1'($urandom_range(0, 1));
      ovf_in     = ($urandom_range(0, 3) == 0);
      clr_sticky = ($urandom_range(0, 15) == 0);
      cond_req   = ($urandom_range(0, 2) == 0);
      cond_code  = 3'($urandom_range(0, 7));
      tick();
    end
    idle_inputs();
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
